// File: rtl/data_mem_resp.sv
// Wait-state data memory for the CPU MEM stage: stalls the pipeline for WAIT_CYCLES+1 cycles
// per access, then returns read data or an error flag during a single RESP cycle.
module data_mem_resp #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        mem_stall,
    output logic        mem_err
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [31:0]             addr_q, data_q;
    logic                    ren_q, wen_q;
    logic [31:0]             din_q, din_d;
    logic                    err_q, err_d;
    logic                    req;
    logic                    latch;
    logic                    resp_go;
    logic                    acc_err;
    logic                    ram_we;
    logic [ADDR_WIDTH-1:0]   ram_idx;
    logic [31:0]             ram [Depth];

    assign req     = mem_ren | mem_wen;
    assign ram_idx = addr_q[ADDR_WIDTH+1:2];

    // Misaligned, beyond the RAM, or an ambiguous read+write request.
    assign acc_err = (addr_q[1:0] != 2'b00)
                  || ((addr_q >> (ADDR_WIDTH + 2)) != 32'd0)
                  || (ren_q && wen_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        resp_go = 1'b0;
        case (state_q)
            StIdle: begin
                if (req) begin
                    latch   = 1'b1;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (!req) begin
                    // CPU withdrew the request: abandon without touching RAM or read data.
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = StResp;
                        resp_go = 1'b1;
                    end
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign ram_we = resp_go & wen_q & ~acc_err;

    always_comb begin
        din_d = din_q;
        if (resp_go) begin
            if (acc_err) begin
                din_d = 32'd0;
            end else if (ren_q) begin
                din_d = ram[ram_idx];
            end
        end
        err_d = resp_go & acc_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            din_q   <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            err_q   <= err_d;
            if (latch) begin
                addr_q <= mem_addr;
                data_q <= mem_dout;
                ren_q  <= mem_ren;
                wen_q  <= mem_wen;
            end
        end
    end

    // Storage is deliberately unreset; a reset during WAIT simply never reaches the write edge.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= data_q;
        end
    end

    assign mem_din   = din_q;
    assign mem_err   = err_q;
    assign mem_stall = rst_n & req & (state_q != StResp);

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, setting a RAM depth of 2^ADDR_WIDTH 32-bit words.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, legal range 1..15, giving the number of wait-state cycles per access.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 mem_ren  input  1  read request from the CPU MEM stage; held stable while mem_stall=1.
REQ-006 mem_wen  input  1  write request from the CPU MEM stage; held stable while mem_stall=1.
REQ-007 mem_addr  input  32  byte address (the CPU ALU result).
REQ-008 mem_dout  input  32  write data from the CPU.
REQ-009 mem_din  output  32  read data returned to the CPU.
REQ-010 mem_stall  output  1  freeze request to the CPU pipeline enables.
REQ-011 mem_err  output  1  access error flag, valid in the RESP state.

Function
REQ-012 The block SHALL implement the states IDLE, WAIT and RESP, encoded in 2 bits, with a 4-bit down-counter cnt.
REQ-013 In IDLE with a request present (mem_ren|mem_wen), the block SHALL, at the clock edge, latch address, data and op, load cnt=WAIT_CYCLES, and go to WAIT.
REQ-014 In WAIT, the block SHALL decrement cnt on each edge and go to RESP on the edge where cnt==1.
REQ-015 RESP SHALL last exactly one cycle, followed by an unconditional return to IDLE; the still-present request SHALL NOT be re-accepted.
REQ-016 mem_stall SHALL equal (mem_ren|mem_wen) & (state!=RESP), combinationally, and SHALL be forced to 0 while rst_n=0.
REQ-017 Latency: a request first seen in cycle 0 SHALL see stall high in cycles 0..WAIT_CYCLES and low in cycle WAIT_CYCLES+1.
REQ-018 A valid write SHALL commit RAM[addr[ADDR_WIDTH+1:2]] <= latched data on the WAIT->RESP edge.
REQ-019 A valid read SHALL load mem_din on the WAIT->RESP edge, and mem_din SHALL hold that value until the next RESP load.
REQ-020 An access SHALL be an error when addr[1:0]!=0 or addr[31:ADDR_WIDTH+2]!=0, or when mem_ren & mem_wen are both set.
REQ-021 On error, the block SHALL leave the RAM unchanged, load mem_din=0, and assert mem_err=1 for the RESP cycle only.
REQ-022 In all other states mem_err SHALL be 0.
REQ-023 When both ren and wen are set, the request SHALL be classified as an error (per REQ-020) and no write SHALL be committed.
REQ-024 If both requests drop while in WAIT, the block SHALL abort to IDLE on the next edge with no RAM write and mem_din unchanged.
REQ-025 The RAM SHALL have no reset, and its contents SHALL be undefined until written.
REQ-026 The request-present check SHALL be evaluated on the RESP->IDLE edge only from IDLE onward, so back-to-back accesses cost WAIT_CYCLES+2 cycles each.

Reset
REQ-027 rst_n low SHALL force, asynchronously: state=IDLE, cnt=0, mem_din=0, mem_err=0, mem_stall=0.
REQ-028 A write pending in WAIT when reset asserts SHALL be discarded, and the RAM word SHALL be unchanged.
REQ-029 After rst_n rises, the first edge with a request SHALL behave as REQ-013.

Verification
REQ-030 W=2: write addr 0x10, data 0xDEADBEEF, then read 0x10 -> stall high 3 cycles each; read returns 0xDEADBEEF in RESP; mem_err=0.
REQ-031 Read 0x12 (misaligned) -> after 3 stall cycles mem_din=0 and mem_err=1 for 1 cycle; RAM unchanged (read 0x10 still gives 0xDEADBEEF).
REQ-032 Write 0x400 with ADDR_WIDTH=8 (out of range) -> mem_err=1 in RESP; word 0 still reads its prior value.
REQ-033 Write 0x20, data 0x12345678; pulse rst_n low in the first WAIT cycle -> outputs zero immediately; a later read of 0x20 does not return 0x12345678.
REQ-034 Drop ren in the second WAIT cycle -> IDLE next edge, mem_din keeps its previous value, no RESP cycle occurs.
REQ-035 Back-to-back read 0x0, then write 0x4 -> exactly 4 cycles per access; stall low only in each RESP cycle.
